// File: rtl/fifo_return_pkg.sv
// Shared helpers for the read-return FIFO: log2, pointer width and
// modulo pointer distance.
package fifo_return_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Address bits plus one wrap bit
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);

  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo_sync_return_rd_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output holds between reads.
module sdp_ram_sync #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_return_rd.sv
// Single-clock FIFO with speculative reads: SUCC commits reads made so far,
// FAIL rewinds the read pointer to the last commit point.
module fifo_sync_return_rd
  import fifo_return_pkg::*;
#(
  parameter int unsigned C_WIDTH            = 32,
  parameter int unsigned C_DEPTH            = 32,
  parameter int unsigned C_PROG_FULL_THRESH = 28,
  parameter int unsigned C_COUNT_WIDTH      = 16,
  parameter int unsigned C_DBG_COUNT_WIDTH  = 16
) (
  input  logic                         CLK_I,
  input  logic                         RSTN_I,
  input  logic                         WR_EN_I,
  input  logic [C_WIDTH-1:0]           WR_DATA_I,
  output logic                         WR_EN_VALID_O,
  output logic                         WR_FULL_O,
  output logic                         WR_PROG_FULL_O,
  output logic [C_COUNT_WIDTH-1:0]     WR_DATA_COUNT_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] WR_EN_NAMES_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] WR_EN_ACCUS_O,
  input  logic                         RD_EN_I,
  output logic                         RD_EN_VALID_O,
  output logic [C_WIDTH-1:0]           RD_DATA_O,
  output logic                         RD_DATA_VALID_O,
  input  logic                         RD_SUCC_I,
  input  logic                         RD_FAIL_I,
  output logic                         RD_EMPTY_O,
  output logic [C_COUNT_WIDTH-1:0]     RD_DATA_COUNT_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] RD_EN_NAMES_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] RD_EN_ACCUS_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] RD_FAIL_CNT_O
);

  localparam int unsigned AW = clog2(C_DEPTH);
  localparam int unsigned PW = ptr_width(C_DEPTH);
  localparam logic [PW-1:0] FULL_CNT = PW'(C_DEPTH);
  localparam logic [PW-1:0] PF_TH    = PW'(C_PROG_FULL_THRESH);
  localparam logic [C_DBG_COUNT_WIDTH-1:0] DBG_ONE = C_DBG_COUNT_WIDTH'(1);

  logic [PW-1:0] wr_ptr, rd_ptr, cmt_ptr, rd_ptr_next;
  logic [PW-1:0] wr_cnt, rd_cnt;
  logic          full, empty, wr_acc, rd_acc;

  // Fullness is against the commit point so uncommitted reads keep their slots
  always_comb begin
    wr_cnt      = PW'(ptr_diff(32'(wr_ptr), 32'(cmt_ptr), PW));
    rd_cnt      = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
    full        = (wr_cnt == FULL_CNT);
    empty       = (rd_ptr == wr_ptr);
    wr_acc      = WR_EN_I & ~full;
    rd_acc      = RD_EN_I & ~empty & ~RD_FAIL_I;
    rd_ptr_next = rd_ptr + PW'(rd_acc);
  end

  assign WR_EN_VALID_O   = wr_acc;
  assign RD_EN_VALID_O   = rd_acc;
  assign WR_FULL_O       = full;
  assign WR_PROG_FULL_O  = (wr_cnt >= PF_TH);
  assign RD_EMPTY_O      = empty;
  assign WR_DATA_COUNT_O = C_COUNT_WIDTH'(wr_cnt);
  assign RD_DATA_COUNT_O = C_COUNT_WIDTH'(rd_cnt);

  // FAIL takes priority over SUCC; writes are independent of both
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cmt_ptr         <= '0;
      RD_DATA_VALID_O <= 1'b0;
    end else begin
      RD_DATA_VALID_O <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (RD_FAIL_I) begin
        rd_ptr <= cmt_ptr;
      end else begin
        rd_ptr <= rd_ptr_next;
        if (RD_SUCC_I) cmt_ptr <= rd_ptr_next;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      WR_EN_NAMES_O <= '0;
      WR_EN_ACCUS_O <= '0;
      RD_EN_NAMES_O <= '0;
      RD_EN_ACCUS_O <= '0;
      RD_FAIL_CNT_O <= '0;
    end else begin
      if (WR_EN_I)   WR_EN_NAMES_O <= WR_EN_NAMES_O + DBG_ONE;
      if (wr_acc)    WR_EN_ACCUS_O <= WR_EN_ACCUS_O + DBG_ONE;
      if (RD_EN_I)   RD_EN_NAMES_O <= RD_EN_NAMES_O + DBG_ONE;
      if (rd_acc)    RD_EN_ACCUS_O <= RD_EN_ACCUS_O + DBG_ONE;
      if (RD_FAIL_I) RD_FAIL_CNT_O <= RD_FAIL_CNT_O + DBG_ONE;
    end
  end

  sdp_ram_sync #(
    .WIDTH (C_WIDTH),
    .DEPTH (C_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK_I),
    .rst_n (RSTN_I),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (WR_DATA_I),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (RD_DATA_O)
  );

endmodule

// File: doc/fifo_sync_return_rd.md
Name: fifo_sync_return_rd

Overview:
- Single-clock FIFO with read-side "return" semantics, the read-side counterpart of the write-return buffering used on the HSPI receive path.
- The producer writes normally. The consumer (HSPI TX serializer) reads speculatively.
- RD_SUCC_I commits all reads made since the last commit point and frees their space. RD_FAIL_I rewinds the read pointer to the last commit point so the frame is retransmitted.
- Sits between the register/response logic and the SPI slave transmit shifter.

Parameters:
- C_WIDTH, 32, data width of both write and read ports.
- C_DEPTH, 32, entries; must be a power of 2, minimum 4.
- C_PROG_FULL_THRESH, 28, WR_PROG_FULL_O asserts when the committed occupancy is at or above this value.
- C_COUNT_WIDTH, 16, width of the data-count outputs; values are zero-extended.
- C_DBG_COUNT_WIDTH, 16, width of the debug counters; they wrap modulo 2^width.

Ports:
- CLK_I  in  1  single clock for both sides.
- RSTN_I  in  1  asynchronous, active-low reset.
- WR_EN_I  in  1  write request.
- WR_DATA_I  in  C_WIDTH  write data.
- WR_EN_VALID_O  out  1  combinational; high when WR_EN_I is accepted (WR_EN_I & ~WR_FULL_O).
- WR_FULL_O  out  1  committed occupancy == C_DEPTH.
- WR_PROG_FULL_O  out  1  committed occupancy >= C_PROG_FULL_THRESH.
- WR_DATA_COUNT_O  out  C_COUNT_WIDTH  committed occupancy (wr_ptr - cmt_ptr).
- WR_EN_NAMES_O  out  C_DBG_COUNT_WIDTH  cycles with WR_EN_I high.
- WR_EN_ACCUS_O  out  C_DBG_COUNT_WIDTH  accepted writes.
- RD_EN_I  in  1  read request.
- RD_EN_VALID_O  out  1  combinational; high when the read is accepted (RD_EN_I & ~RD_EMPTY_O & ~RD_FAIL_I).
- RD_DATA_O  out  C_WIDTH  read data; registered; holds its value between reads.
- RD_DATA_VALID_O  out  1  one-cycle pulse, the cycle after an accepted read.
- RD_SUCC_I  in  1  commit pulse.
- RD_FAIL_I  in  1  rewind pulse.
- RD_EMPTY_O  out  1  nothing left to read speculatively (rd_ptr == wr_ptr).
- RD_DATA_COUNT_O  out  C_COUNT_WIDTH  unread entries (wr_ptr - rd_ptr).
- RD_EN_NAMES_O  out  C_DBG_COUNT_WIDTH  cycles with RD_EN_I high.
- RD_EN_ACCUS_O  out  C_DBG_COUNT_WIDTH  accepted reads, including re-reads after a rewind.
- RD_FAIL_CNT_O  out  C_DBG_COUNT_WIDTH  count of RD_FAIL_I pulses.

Behaviour:
- Pointers: wr_ptr, rd_ptr (speculative) and cmt_ptr (committed).
  - Each is log2(C_DEPTH)+1 bits; the MSB is the wrap bit.
  - Addresses use the low bits.
  - Pointer differences are computed modulo 2^(log2(C_DEPTH)+1).
- Invariant: cmt_ptr <= rd_ptr <= wr_ptr (circular order).
- Reset (RSTN_I low, asynchronous):
  - All pointers 0.
  - RD_DATA_O = 0, RD_DATA_VALID_O = 0.
  - RD_EMPTY_O = 1, WR_FULL_O = 0, WR_PROG_FULL_O = 0.
  - All counts and debug counters 0.
  - RAM contents are don't-care.
- Write:
  - On an accepted write, mem[wr_ptr] <= WR_DATA_I and wr_ptr += 1.
  - Fullness is measured against cmt_ptr, so space is reserved for uncommitted reads.
  - WR_EN_I while full is dropped; only NAMES increments.
- Read (std mode):
  - On an accepted read, RD_DATA_O <= mem[rd_ptr] and rd_ptr += 1; RD_DATA_VALID_O pulses the next cycle. Latency is 1.
  - RD_EN_I while empty is ignored.
  - Back-to-back reads are allowed every cycle.
- Write/read same cycle on an empty FIFO: the read is not accepted (no bypass). Data is readable the next cycle.
- RD_SUCC_I: cmt_ptr <= rd_ptr_next, where rd_ptr_next includes a read accepted in the same cycle. Space becomes visible to the writer the next cycle.
- RD_FAIL_I:
  - rd_ptr <= cmt_ptr.
  - A same-cycle RD_EN_I is rejected.
  - A same-cycle RD_DATA_VALID_O from the previous cycle's read still pulses.
  - cmt_ptr is unchanged.
- RD_SUCC_I and RD_FAIL_I in the same cycle: FAIL wins and SUCC is ignored.
- Writes proceed independently of SUCC and FAIL in every cycle.
- Full occurs with cmt_ptr lagging: the writer stalls until SUCC, even when RD_EMPTY_O = 1.
- A FAIL with nothing outstanding (rd_ptr == cmt_ptr) is a no-op apart from RD_FAIL_CNT_O.
- Status outputs are combinational from the registered pointers.

Decomposition:
- Package fifo_return_pkg holds:
  - a clog2 function;
  - the pointer-width localparam derivation;
  - a ptr_diff helper function.
- One sub-module: sdp_ram_sync, a simple dual-port RAM with one write port, one registered read port, C_WIDTH x C_DEPTH. It infers BRAM/LUTRAM.
- Pointer and control logic stays in the top.

Test Plan:
- Reset, then write 0x11..0x14, read 4 -> RD_DATA_O = 0x11,0x12,0x13,0x14 on consecutive VALID pulses; RD_EMPTY_O = 1; WR_DATA_COUNT_O = 4 (uncommitted).
- Continuing from the above, pulse RD_FAIL_I, read 4 again -> same 0x11..0x14 sequence; RD_FAIL_CNT_O = 1; RD_EN_ACCUS_O = 8.
- Pulse RD_SUCC_I -> WR_DATA_COUNT_O = 0 next cycle; a following FAIL leaves RD_EMPTY_O = 1 with no replay.
- Write 32 entries (C_DEPTH = 32) and read all 32 without SUCC -> WR_FULL_O = 1 and the 33rd write is dropped (NAMES = 33, ACCUS = 32). After SUCC, WR_FULL_O = 0 and a write is accepted.
- RD_EN_I, RD_SUCC_I and RD_FAIL_I in the same cycle with 2 entries outstanding -> read rejected (RD_EN_VALID_O = 0), rd_ptr rewound, cmt_ptr unchanged.
- Drop RSTN_I mid-burst, asynchronously between clock edges -> outputs take their reset values immediately; after release, EMPTY = 1 and all counts are 0.
